qei_speed: RTL and testbench
============================

QEI_SPEED -- requirements
Module: qei_speed

Interface
REQ-001 SHALL have parameter nbits, default 16: width of the QEI position count input.
REQ-002 SHALL have parameter obits, default 16: width of the signed speed output, with obits <= nbits.
REQ-003 SHALL have parameter period, default 48000: sample period in clk cycles (1 ms at 48 MHz), with period >= 2.
REQ-004 SHALL have port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port clr, input, 1: synchronous clear, active-high.
REQ-007 SHALL have port en, input, 1: enable, active-high.
REQ-008 SHALL have port qei_val, input, nbits: free-running position count from the QEI stage, unsigned and wrapping.
REQ-009 SHALL have port speed, output, obits: signed counts per period, two's complement.
REQ-010 SHALL have port valid, output, 1: one-cycle strobe marking a new speed value.
REQ-011 SHALL have port sat, output, 1: high when the current speed value was saturated.

Function
REQ-012 SHALL count en-qualified cycles from 0 to period-1 and raise an internal tick when the count reaches period-1.
- The counter wraps to 0 after the tick.
REQ-013 SHALL use a state machine with states PRIME, FILL and RUN.
- FILL exists only when the filter is compiled in (see REQ-024).
REQ-014 SHALL handle a tick in PRIME as follows:
- Capture qei_val into prev.
- Do not assert valid.
- Go to FILL if the filter is compiled in, otherwise RUN.
REQ-015 SHALL, on every tick in FILL or RUN, compute delta = qei_val - prev modulo 2^nbits, interpret it as signed nbits, then set prev <= qei_val.
REQ-016 SHALL handle wrap-around correctly.
- Example with nbits=16: prev 16'hFFFE to 16'h0003 gives delta +5.
- The reverse direction gives -5.
REQ-017 SHALL saturate the result to the signed obits range [-2^(obits-1), 2^(obits-1)-1].
- sat is set to 1 when clipping occurred, otherwise 0.
REQ-018 SHALL update speed and sat, and pulse valid high for exactly one cycle, on the cycle after the tick (latency 1).
REQ-019 SHALL hold speed and sat unchanged between updates.
REQ-020 SHALL, while en=0, freeze the counter and state, generate no tick, hold valid=0 and hold all outputs.
REQ-021 SHALL give priority rst > clr > en.
REQ-022 SHALL, on clr=1, perform the following:
- Set counter to 0, state to PRIME, speed to 0, sat to 0 and valid to 0.
- Clear the filter history.
- The next tick only primes.

Reset
REQ-023 SHALL, while rst=0 at a clock edge, set counter=0, state=PRIME, prev=0, speed=0, valid=0 and sat=0, and clear the filter history.
- Reset asserted mid-period discards the partial period.

Configuration
REQ-024 SHALL recognise the macro QEI_SPEED_FILTER_EN.
- Defined: speed = (sum of the last 4 saturated deltas) >>> 2 (arithmetic shift, rounding toward minus infinity).
- Defined: the sum is held at obits+2 bits.
- Defined: FILL collects 4 deltas; the first valid comes on the 4th delta, then the block goes to RUN.
- Defined: sat = OR of the 4 history sat flags.
- Undefined: speed = saturated delta directly, with no FILL state and no history storage.

Verification (bench: period=10, nbits=16, obits=8)
REQ-025 SHALL check: rst low then released, qei_val held at 100 -> no valid at the first tick; valid one cycle after the second tick with speed=0, sat=0.
REQ-026 SHALL check: qei_val +5 per period -> each valid gives speed=5; valid is exactly 1 cycle wide and 10 cycles apart.
REQ-027 SHALL check: qei_val 16'hFFFE then 16'h0003 -> speed=+5; then back to 16'hFFFE -> speed=-5.
REQ-028 SHALL check: delta +300 -> speed=127, sat=1; delta -300 -> speed=-128, sat=1; delta +10 -> sat=0.
REQ-029 SHALL check: clr pulsed at counter=5 -> counter restarts; the next tick 10 cycles later primes with no valid; en=0 for 20 cycles -> no valid and outputs held.
REQ-030 SHALL check: QEI_SPEED_FILTER_EN defined, deltas 4, 8, 12, 16 -> first valid only after the 4th delta with speed=10; undefined -> the first valid gives speed=4.

Source files
------------

// File: rtl/qei_speed_if.sv
`default_nettype none
// ============================================================================
// Module   : qei_speed_if
// Brief    : Control/result bundle between a QEI speed estimator and its user.
// Revision : 1.0 - initial release
// ============================================================================
interface qei_speed_if #(
    parameter int nbits = 16,
    parameter int obits = 16
);
    logic                    clr;
    logic                    en;
    logic [nbits-1:0]        qei_val;
    logic signed [obits-1:0] speed;
    logic                    valid;
    logic                    sat;

    modport master (
        output clr, en, qei_val,
        input  speed, valid, sat
    );

    modport slave (
        input  clr, en, qei_val,
        output speed, valid, sat
    );
endinterface
`default_nettype wire

// File: rtl/qei_speed.sv
`default_nettype none
// ============================================================================
// Module   : qei_speed
// Brief    : Periodic speed estimate (counts per period) from a wrapping QEI
//            position count. Optional 4-tap moving average: QEI_SPEED_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module qei_speed #(
    parameter int nbits  = 16,
    parameter int obits  = 16,
    parameter int period = 48000
) (
    input wire         clk,
    input wire         rst,
    qei_speed_if.slave bus
);
    localparam int                      c_cntW   = $clog2(period);
    localparam logic [c_cntW-1:0]       c_last   = c_cntW'(period - 1);
    localparam logic signed [nbits-1:0] c_satMax = nbits'((64'sd1 <<< (obits - 1)) - 64'sd1);
    localparam logic signed [nbits-1:0] c_satMin = nbits'(-(64'sd1 <<< (obits - 1)));

    typedef enum logic [1:0] {
        PRIME = 2'd0,
`ifdef QEI_SPEED_FILTER_EN
        FILL  = 2'd1,
`endif
        RUN   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic                    w_emit;
    logic [c_cntW-1:0]       r_cnt;
    logic [nbits-1:0]        r_prev;
    logic signed [obits-1:0] r_speed;
    logic                    r_valid;
    logic                    r_sat;
    logic                    w_tick;
    logic signed [nbits-1:0] w_delta;
    logic signed [obits-1:0] w_satDelta;
    logic                    w_satFlag;
    logic signed [obits-1:0] w_outSpeed;
    logic                    w_outSat;

    assign w_tick  = bus.en && (r_cnt == c_last);
    assign w_delta = signed'(bus.qei_val - r_prev);

    always_comb begin
        w_satDelta = w_delta[obits-1:0];
        w_satFlag  = 1'b0;
        if (w_delta > c_satMax) begin
            w_satDelta = c_satMax[obits-1:0];
            w_satFlag  = 1'b1;
        end else if (w_delta < c_satMin) begin
            w_satDelta = c_satMin[obits-1:0];
            w_satFlag  = 1'b1;
        end
    end

`ifdef QEI_SPEED_FILTER_EN
    // Three stored deltas plus the current one form the 4-tap window.
    logic signed [obits-1:0] r_hist [3];
    logic [2:0]              r_histSat;
    logic [1:0]              r_fillCnt;
    logic signed [obits+1:0] w_sum;

    function automatic logic signed [obits+1:0] ext(input logic signed [obits-1:0] x);
        return {{2{x[obits-1]}}, x};
    endfunction

    assign w_sum      = ext(r_hist[0]) + ext(r_hist[1]) + ext(r_hist[2]) + ext(w_satDelta);
    assign w_outSpeed = obits'(w_sum >>> 2);
    assign w_outSat   = (|r_histSat) | w_satFlag;

    always_ff @(posedge clk) begin
        if (!rst || bus.clr) begin
            r_hist    <= '{default: '0};
            r_histSat <= '0;
            r_fillCnt <= '0;
        end else if (w_tick && r_state != PRIME) begin
            r_hist[0] <= w_satDelta;
            r_hist[1] <= r_hist[0];
            r_hist[2] <= r_hist[1];
            r_histSat <= {r_histSat[1:0], w_satFlag};
            if (r_state == FILL) begin
                r_fillCnt <= r_fillCnt + 2'd1;
            end
        end
    end
`else
    assign w_outSpeed = w_satDelta;
    assign w_outSat   = w_satFlag;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= PRIME;
        end else if (bus.clr) begin
            r_state <= PRIME;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_emit      = 1'b0;
        if (w_tick) begin
            case (r_state)
`ifdef QEI_SPEED_FILTER_EN
                PRIME: w_nextState = FILL;
                FILL: begin
                    if (r_fillCnt == 2'd3) begin
                        w_nextState = RUN;
                        w_emit      = 1'b1;
                    end
                end
`else
                PRIME: w_nextState = RUN;
`endif
                RUN:     w_emit      = 1'b1;
                default: w_nextState = PRIME;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_prev  <= '0;
            r_speed <= '0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
        end else if (bus.clr) begin
            r_cnt   <= '0;
            r_speed <= '0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bus.en) begin
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                if (w_tick) begin
                    r_prev <= bus.qei_val;
                end
                if (w_emit) begin
                    r_speed <= w_outSpeed;
                    r_sat   <= w_outSat;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.speed = r_speed;
    assign bus.valid = r_valid;
    assign bus.sat   = r_sat;
endmodule
`default_nettype wire

// File: tb/tb_qei_speed.sv
`default_nettype none
// ============================================================================
// Module   : tb_qei_speed
// Brief    : Self-checking bench for qei_speed against a per-period reference
//            model (honours QEI_SPEED_FILTER_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_qei_speed;
    localparam int c_nbits  = 16;
    localparam int c_obits  = 8;
    localparam int c_period = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    qei_speed_if #(.nbits(c_nbits), .obits(c_obits)) bus ();

    qei_speed #(.nbits(c_nbits), .obits(c_obits), .period(c_period)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: one update per sample period.
    bit          primed;
    logic [15:0] mPrev;
    int          hist[$];
    bit          histSat[$];
    int          expSpeed;
    bit          expSat;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        primed   = 1'b0;
        expSpeed = 0;
        expSat   = 1'b0;
        hist.delete();
        histSat.delete();
    endtask

    task automatic modelTick(input logic [15:0] val, output bit emit);
        logic [15:0] diff;
        int d, s, sum;
        bit f, anySat;
        emit = 1'b0;
        if (!primed) begin
            primed = 1'b1;
            mPrev  = val;
            return;
        end
        diff  = val - mPrev;
        d     = $signed(diff);
        mPrev = val;
        if (d > 127) begin s = 127; f = 1'b1; end
        else if (d < -128) begin s = -128; f = 1'b1; end
        else begin s = d; f = 1'b0; end
`ifdef QEI_SPEED_FILTER_EN
        hist.push_back(s);
        histSat.push_back(f);
        if (hist.size() > 4) begin
            void'(hist.pop_front());
            void'(histSat.pop_front());
        end
        if (hist.size() == 4) begin
            sum    = 0;
            anySat = 1'b0;
            foreach (hist[i]) begin
                sum    += hist[i];
                anySat |= histSat[i];
            end
            expSpeed = (sum >= 0) ? sum / 4 : -((-sum + 3) / 4);
            expSat   = anySat;
            emit     = 1'b1;
        end
`else
        sum      = 0;
        anySat   = 1'b0;
        expSpeed = s + sum;
        expSat   = f | anySat;
        emit     = 1'b1;
`endif
    endtask

    task automatic checkOutputs(input string tag, input bit emit);
        check({tag, ".valid"}, bus.valid, emit);
        check({tag, ".speed"}, bus.speed, expSpeed);
        check({tag, ".sat"},   bus.sat,   expSat);
    endtask

    // One full sample period of enabled edges; optional en=0 gap of 20 cycles.
    task automatic runPeriod(input logic [15:0] val, input int pauseAt);
        bit emit;
        bus.qei_val = val;
        for (int k = 1; k <= c_period; k++) begin
            if (k - 1 == pauseAt) begin
                bus.en = 1'b0;
                for (int p = 0; p < 20; p++) begin
                    bus.qei_val = 16'($urandom);
                    @(posedge clk); #1;
                    checkOutputs("paused", 1'b0);
                end
                bus.qei_val = val;
                bus.en      = 1'b1;
            end
            @(posedge clk); #1;
            emit = 1'b0;
            if (k == c_period) modelTick(val, emit);
            checkOutputs("period", emit);
        end
    endtask

    task automatic clrMid();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutputs("preclr", 1'b0);
        end
        bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        modelClear();
        checkOutputs("clr", 1'b0);
    endtask

    logic [15:0] cur;
    int          d;

    initial begin
        bus.clr     = 1'b0;
        bus.en      = 1'b1;
        bus.qei_val = 16'd100;
        modelClear();
        mPrev = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutputs("reset", 1'b0);
        rst = 1'b1;

        // Prime then zero speed
        runPeriod(16'd100, -1);
        runPeriod(16'd100, -1);

        cur = 16'd100;
        for (int i = 0; i < 5; i++) begin
            cur = cur + 16'd5;
            runPeriod(cur, -1);
        end

        runPeriod(16'hFFFE, -1);
        runPeriod(16'h0003, -1);
`ifndef QEI_SPEED_FILTER_EN
        check("wrapPos", bus.speed, 5);
`endif
        runPeriod(16'hFFFE, -1);
`ifndef QEI_SPEED_FILTER_EN
        check("wrapNeg", bus.speed, -5);
`endif

        cur = 16'hFFFE + 16'd300;
        runPeriod(cur, -1);
`ifndef QEI_SPEED_FILTER_EN
        check("satPos", bus.speed, 127);
        check("satPosFlag", bus.sat, 1);
`endif
        cur = cur - 16'd300;
        runPeriod(cur, -1);
`ifndef QEI_SPEED_FILTER_EN
        check("satNeg", bus.speed, -128);
        check("satNegFlag", bus.sat, 1);
`endif
        cur = cur + 16'd10;
        runPeriod(cur, -1);
`ifndef QEI_SPEED_FILTER_EN
        check("noSatFlag", bus.sat, 0);
`endif

        // Clear mid-period, re-prime, then ramp 4/8/12/16
        clrMid();
        runPeriod(cur, -1);
        cur = cur + 16'd4;
        runPeriod(cur, -1);
`ifndef QEI_SPEED_FILTER_EN
        check("firstValid", bus.speed, 4);
`endif
        cur = cur + 16'd8;
        runPeriod(cur, -1);
        cur = cur + 16'd12;
        runPeriod(cur, -1);
        cur = cur + 16'd16;
        runPeriod(cur, -1);
`ifdef QEI_SPEED_FILTER_EN
        check("filtAvg", bus.speed, 10);
`endif

        cur = cur + 16'd3;
        runPeriod(cur, 4);

        for (int i = 0; i < 24; i++) begin
            d   = int'($urandom_range(0, 800)) - 400;
            cur = cur + 16'(d);
            runPeriod(cur, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
